otp_pad_engine: RTL and testbench

OTP_PAD_ENGINE -- requirements
Module: otp_pad_engine

---
 rtl/otp_pad_engine.sv | 99 +++++++++
 tb/tb_otp_pad_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_pad_engine.sv
// One-time-pad engine: LFSR pads are stored per slot on encrypt and burned on decrypt.
// Latency: one cycle from accept to out_valid, through a single output register.
// Backpressure: in_ready drops while a result is held, and for encrypt while the write slot is live.
module otp_pad_engine #(
    parameter int DW = 8,
    parameter int DEPTH = 8,
    parameter logic [DW-1:0] TAPS = 8'hB8,
    parameter logic [DW-1:0] SEED = 8'h01,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] in_index,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_index,
    output logic          out_err,
    output logic          full,
    output logic [AW:0]   live_count
);

    logic [DW-1:0]    lfsr;
    logic [DW-1:0]    lfsr_next;
    logic [DW-1:0]    pad [DEPTH];
    logic [DEPTH-1:0] live;
    logic [AW-1:0]    wr_ptr;
    logic             accept;
    logic             enc_acc;
    logic             dec_acc;
    logic             dec_hit;

    assign full      = live[wr_ptr];
    assign in_ready  = ena & ~flush & (~out_valid | out_ready) & (in_mode | ~full);
    assign accept    = in_valid & in_ready;
    assign enc_acc   = accept & ~in_mode;
    assign dec_acc   = accept & in_mode;
    assign dec_hit   = live[in_index];
    assign lfsr_next = {lfsr[DW-2:0], ^(lfsr & TAPS)};

    always_comb begin
        live_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live_count = live_count + {{AW{1'b0}}, live[i]};
        end
    end

    // Pad contents are only ever read behind a live bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (enc_acc) begin
            pad[wr_ptr] <= lfsr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= SEED;
            live      <= '0;
            wr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_err   <= 1'b0;
        end else begin
            if (flush) begin
                live   <= '0;
                wr_ptr <= '0;
            end else if (enc_acc) begin
                live[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + AW'(1);
                lfsr         <= lfsr_next;
            end else if (dec_acc && dec_hit) begin
                live[in_index] <= 1'b0;
            end

            if (accept) begin
                out_valid <= 1'b1;
                out_err   <= dec_acc & ~dec_hit;
                out_index <= in_mode ? in_index : wr_ptr;
                if (enc_acc) begin
                    out_data <= in_data ^ lfsr;
                end else if (dec_hit) begin
                    out_data <= in_data ^ pad[in_index];
                end else begin
                    out_data <= '0;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_otp_pad_engine.sv
// Bench for otp_pad_engine: directed vector table, corner-case sequences, then
// randomized traffic against a slot-level reference model.
module tb_otp_pad_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic       in_mode;
    logic [7:0] in_data;
    logic [2:0] in_index;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_index;
    logic       out_err;
    logic       full;
    logic [3:0] live_count;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    otp_pad_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .in_index   (in_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_err    (out_err),
        .full       (full),
        .live_count (live_count)
    );

    typedef struct packed {
        logic       mode;
        logic [7:0] data;
        logic [2:0] idx;
        logic [7:0] exp_data;
        logic [2:0] exp_idx;
        logic       exp_err;
        logic [3:0] exp_lc;
    } vec_t;

    vec_t vecs [8];

    // Reference model state, kept per slot rather than as packed registers.
    int m_pad [8];
    bit m_live [8];
    int m_wr;
    int m_lfsr;
    bit m_ov;
    int m_od;
    int m_oi;
    bit m_oe;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = 8'h00;
        in_index  = 3'd0;
        flush     = 1'b0;
        ena       = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic do_reset;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_live_count", int'(live_count), 0);
        rst_n = 1'b1;
    endtask

    // One accepted transaction: present it, confirm readiness, clock it in.
    task automatic xact(input logic mode, input logic [7:0] data, input logic [2:0] idx);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        in_index = idx;
        #1;
        chk("xact_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int lfsr_step(input int v);
        return ((v * 2) % 256) + ($countones(v & 'hB8) % 2);
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_live[i]);
        return n;
    endfunction

    initial begin
        bit exp_rdy;
        bit acc;

        vecs[0] = '{1'b0, 8'hA5, 3'd0, 8'hA4, 3'd0, 1'b0, 4'd1};
        vecs[1] = '{1'b0, 8'h3C, 3'd0, 8'h3E, 3'd1, 1'b0, 4'd2};
        vecs[2] = '{1'b1, 8'hA4, 3'd0, 8'hA5, 3'd0, 1'b0, 4'd1};
        vecs[3] = '{1'b1, 8'hA4, 3'd0, 8'h00, 3'd0, 1'b1, 4'd1};
        vecs[4] = '{1'b1, 8'h3E, 3'd1, 8'h3C, 3'd1, 1'b0, 4'd0};
        vecs[5] = '{1'b0, 8'h00, 3'd0, 8'h04, 3'd2, 1'b0, 4'd1};
        vecs[6] = '{1'b1, 8'h04, 3'd2, 8'h00, 3'd2, 1'b0, 4'd0};
        vecs[7] = '{1'b1, 8'h55, 3'd5, 8'h00, 3'd5, 1'b1, 4'd0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            xact(vecs[i].mode, vecs[i].data, vecs[i].idx);
            chk("vec_out_valid", int'(out_valid), 1);
            chk("vec_out_data", int'(out_data), int'(vecs[i].exp_data));
            chk("vec_out_index", int'(out_index), int'(vecs[i].exp_idx));
            chk("vec_out_err", int'(out_err), int'(vecs[i].exp_err));
            chk("vec_live_count", int'(live_count), int'(vecs[i].exp_lc));
        end
        tick();
        chk("vec_drain", int'(out_valid), 0);

        // Fill every slot, then free slot 0 and wrap the write pointer onto it.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            xact(1'b0, 8'h00, 3'd0);
            chk("fill_index", int'(out_index), i);
        end
        in_valid = 1'b1;
        in_mode  = 1'b0;
        #1;
        chk("fill_full", int'(full), 1);
        chk("fill_enc_blocked", int'(in_ready), 0);
        chk("fill_live_count", int'(live_count), 8);
        xact(1'b1, 8'h01, 3'd0);
        chk("fill_dec_data", int'(out_data), 0);
        chk("fill_dec_err", int'(out_err), 0);
        chk("fill_not_full", int'(full), 0);
        xact(1'b0, 8'h00, 3'd0);
        chk("wrap_index", int'(out_index), 0);
        chk("wrap_data", int'(out_data), 'h1C);

        // Output stall with a pending result, then a bubble-free reload.
        do_reset();
        out_ready = 1'b0;
        xact(1'b0, 8'hA5, 3'd0);
        chk("stall_first_valid", int'(out_valid), 1);
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", int'(in_ready), 0);
            tick();
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'(out_data), 'hA4);
            chk("stall_index", int'(out_index), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("b2b_valid", int'(out_valid), 1);
        chk("b2b_data", int'(out_data), 'h3E);
        chk("b2b_index", int'(out_index), 1);
        tick();
        chk("b2b_drain", int'(out_valid), 0);

        // Flush keeps the LFSR position but empties every slot.
        do_reset();
        for (int i = 0; i < 3; i++) xact(1'b0, 8'h00, 3'd0);
        chk("flush_pre_count", int'(live_count), 3);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", int'(in_ready), 0);
        tick();
        flush = 1'b0;
        chk("flush_count", int'(live_count), 0);
        chk("flush_full", int'(full), 0);
        xact(1'b1, 8'h00, 3'd1);
        chk("flush_dec_err", int'(out_err), 1);
        chk("flush_dec_data", int'(out_data), 0);
        xact(1'b0, 8'h00, 3'd0);
        chk("flush_enc_data", int'(out_data), 'h08);
        chk("flush_enc_index", int'(out_index), 0);

        // Asynchronous reset while a result is held.
        do_reset();
        out_ready = 1'b0;
        xact(1'b0, 8'h55, 3'd0);
        chk("arst_pre_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_data", int'(out_data), 0);
        chk("arst_count", int'(live_count), 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("arst_no_output", int'(out_valid), 0);
        xact(1'b0, 8'h00, 3'd0);
        chk("arst_enc_data", int'(out_data), 'h01);
        chk("arst_enc_index", int'(out_index), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            m_pad[i]  = 0;
            m_live[i] = 1'b0;
        end
        m_wr = 0; m_lfsr = 1; m_ov = 1'b0; m_od = 0; m_oi = 0; m_oe = 1'b0;
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mode   = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            in_index  = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            ena       = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            #1;
            exp_rdy = ena && !flush && (!m_ov || out_ready) && (in_mode || !m_live[m_wr]);
            chk("rnd_in_ready", int'(in_ready), int'(exp_rdy));
            chk("rnd_full", int'(full), int'(m_live[m_wr]));
            chk("rnd_live_count", int'(live_count), model_count());
            acc = in_valid && exp_rdy;
            if (acc) begin
                m_ov = 1'b1;
                if (!in_mode) begin
                    m_od = int'(in_data) ^ m_lfsr;
                    m_oi = m_wr;
                    m_oe = 1'b0;
                    m_pad[m_wr]  = m_lfsr;
                    m_live[m_wr] = 1'b1;
                    m_wr   = (m_wr + 1) % 8;
                    m_lfsr = lfsr_step(m_lfsr);
                end else begin
                    m_oi = int'(in_index);
                    if (m_live[in_index]) begin
                        m_od = int'(in_data) ^ m_pad[in_index];
                        m_oe = 1'b0;
                        m_live[in_index] = 1'b0;
                    end else begin
                        m_od = 0;
                        m_oe = 1'b1;
                    end
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 8; i++) m_live[i] = 1'b0;
                m_wr = 0;
            end
            tick();
            chk("rnd_out_valid", int'(out_valid), int'(m_ov));
            if (m_ov) begin
                chk("rnd_out_data", int'(out_data), m_od);
                chk("rnd_out_index", int'(out_index), m_oi);
                chk("rnd_out_err", int'(out_err), int'(m_oe));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
